pipe_stage_latch: RTL

//  Parametrised inter-stage pipeline latch for the 5-stage core: D/X, X/M and M/W boundaries.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_payload_reg.sv | 30 +++
 rtl/pipe_stage_latch.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline latches: latch states,
// the bubble control word and default field widths.
package pipe_pkg;

  localparam int DEFAULT_CTRL_W = 14;
  localparam int DEFAULT_RD_W   = 5;

  // A bubble is an all-zero control bundle so downstream stages do nothing.
  localparam logic [DEFAULT_CTRL_W-1:0] BUBBLE_CTRL = '0;

  typedef enum logic [1:0] {
    STATE_EMPTY = 2'd0,
    STATE_MAIN  = 2'd1,
    STATE_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// W-bit payload register with load enable and synchronous clear; the clear
// value doubles as the asynchronous reset value.
module pipe_payload_reg #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Clear has priority so a squash can never be overridden by a load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= CLR_VAL;
    end else if (i_clr) begin
      r_q <= CLR_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline latch with valid/ready handshake, flush-to-bubble and
// an optional one-entry skid buffer that keeps in_ready registered.
module pipe_stage_latch
  import pipe_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int CTRL_W    = DEFAULT_CTRL_W,
  parameter int RD_W      = DEFAULT_RD_W,
  parameter bit SKID_EN   = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_WORDS*WORD_W-1:0] in_words,
  input  logic [CTRL_W-1:0]           in_ctrl_signals,
  input  logic [RD_W-1:0]             in_rd,
  input  logic                        in_branch_taken,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_WORDS*WORD_W-1:0] out_words,
  output logic [CTRL_W-1:0]           out_ctrl_signals,
  output logic [RD_W-1:0]             out_rd,
  output logic                        out_branch_taken
);

  localparam int DATA_W = NUM_WORDS * WORD_W;
  localparam int PAY_W  = DATA_W + CTRL_W + RD_W + 1;
  localparam logic [PAY_W-1:0] BUBBLE_PAYLOAD =
    {1'b0, {RD_W{1'b0}}, CTRL_W'(BUBBLE_CTRL), {DATA_W{1'b0}}};

  state_t r_state;
  state_t w_nextState;

  logic             w_inFire;
  logic             w_outFire;
  logic             w_outValid;
  logic             w_mainLoad;
  logic             w_mainClear;
  logic             w_skidLoad;
  logic             w_skidClear;
  logic [PAY_W-1:0] w_inPayload;
  logic [PAY_W-1:0] w_mainD;
  logic [PAY_W-1:0] w_mainQ;
  logic [PAY_W-1:0] w_skidQ;

  assign w_inPayload = {in_branch_taken, in_rd, in_ctrl_signals, in_words};
  assign w_inFire    = in_valid & in_ready;
  assign w_outFire   = w_outValid & out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= STATE_EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Without the skid buffer in_ready already blocks a fire while stalled,
  // so the FULL transition is only ever taken when SKID_EN is set.
  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = STATE_EMPTY;
    end else begin
      case (r_state)
        STATE_EMPTY: if (w_inFire) w_nextState = STATE_MAIN;
        STATE_MAIN: begin
          if (w_inFire && !w_outFire) begin
            w_nextState = SKID_EN ? STATE_FULL : STATE_MAIN;
          end else if (!w_inFire && w_outFire) begin
            w_nextState = STATE_EMPTY;
          end
        end
        STATE_FULL:  if (w_outFire) w_nextState = STATE_MAIN;
        default:     w_nextState = STATE_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_outValid  = (r_state != STATE_EMPTY);
    w_mainLoad  = 1'b0;
    w_mainClear = flush;
    w_skidLoad  = 1'b0;
    w_skidClear = flush;
    w_mainD     = w_inPayload;
    case (r_state)
      STATE_EMPTY: w_mainLoad = w_inFire;
      STATE_MAIN: begin
        w_mainLoad  = w_inFire & w_outFire;
        w_skidLoad  = w_inFire & ~w_outFire;
        w_mainClear = flush | (~w_inFire & w_outFire);
      end
      STATE_FULL: begin
        w_mainD     = w_skidQ;
        w_mainLoad  = w_outFire;
        w_skidClear = flush | w_outFire;
      end
      default: w_mainClear = 1'b1;
    endcase
  end

  pipe_payload_reg #(
    .W       (PAY_W),
    .CLR_VAL (BUBBLE_PAYLOAD)
  ) u_main (
    .clock (clock),
    .reset (reset),
    .i_en  (w_mainLoad),
    .i_clr (w_mainClear),
    .i_d   (w_mainD),
    .o_q   (w_mainQ)
  );

  pipe_payload_reg #(
    .W       (PAY_W),
    .CLR_VAL (BUBBLE_PAYLOAD)
  ) u_skid (
    .clock (clock),
    .reset (reset),
    .i_en  (w_skidLoad),
    .i_clr (w_skidClear),
    .i_d   (w_inPayload),
    .o_q   (w_skidQ)
  );

  // The registered form breaks the out_ready -> in_ready combinational path.
  if (SKID_EN) begin : g_skidReady
    logic r_inReady;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_inReady <= 1'b0;
      end else begin
        r_inReady <= (w_nextState != STATE_FULL);
      end
    end
    assign in_ready = r_inReady;
  end else begin : g_plainReady
    assign in_ready = ~reset & (out_ready | ~w_outValid);
  end

  assign out_valid = w_outValid;
  assign {out_branch_taken, out_rd, out_ctrl_signals, out_words} = w_mainQ;

endmodule
